// File: rtl/simon_encrypt_ctrl.sv
// Iterative Simon32/64 encryption controller: one registered round is reused for
// all rounds while the key schedule is expanded alongside it, one word per cycle.

module simon_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] key_in,
  output logic [15:0] x_out,
  output logic [15:0] y_out
);

  function automatic logic [15:0] rol1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  function automatic logic [15:0] rol2(input logic [15:0] v);
    return {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] rol8(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // One Feistel round, registered; holds its result while not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out <= 16'h0000;
      y_out <= 16'h0000;
    end else if (en) begin
      x_out <= y_in ^ (rol1(x_in) & rol8(x_in)) ^ rol2(x_in) ^ key_in;
      y_out <= x_in;
    end
  end

endmodule

module simon_encrypt_ctrl #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [15:0] pt_x,
  input  logic [15:0] pt_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] ct_x,
  output logic [15:0] ct_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // z0 sequence written with z0[0] as the MSB, so bit i is at index 31-i
  localparam logic [31:0] Z0_SEQ = 32'b1111_1010_0010_0101_0110_0001_1100_1101;

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  cnt_r;
  logic [15:0] kr_r [4];
  logic [15:0] hold_x_r;
  logic [15:0] hold_y_r;
  logic [15:0] t_s;
  logic [15:0] knew_s;
  logic [15:0] x_in_s;
  logic [15:0] y_in_s;
  logic [15:0] x_out_s;
  logic [15:0] y_out_s;
  logic        round_en_s;

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (cnt_r == 5'(ROUNDS - 1)) state_next_s = DONE;
        else                         state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state != IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != IDLE);
    end
  end

  // Key expansion and round operand selection
  always_comb begin
    t_s        = ror3(kr_r[3]) ^ kr_r[1];
    knew_s     = kr_r[0] ^ t_s ^ ror1(t_s) ^ 16'hFFFC ^ {15'd0, Z0_SEQ[5'd31 - cnt_r]};
    round_en_s = (state_r == RUN);
    if (cnt_r == 5'd0) begin
      x_in_s = hold_x_r;
      y_in_s = hold_y_r;
    end else begin
      x_in_s = x_out_s;
      y_in_s = y_out_s;
    end
  end

  // Operand latch, key shift register, round counter and ciphertext capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 5'd0;
      kr_r[0]  <= 16'h0000;
      kr_r[1]  <= 16'h0000;
      kr_r[2]  <= 16'h0000;
      kr_r[3]  <= 16'h0000;
      hold_x_r <= 16'h0000;
      hold_y_r <= 16'h0000;
      ct_x     <= 16'h0000;
      ct_y     <= 16'h0000;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            kr_r[0]  <= key[15:0];
            kr_r[1]  <= key[31:16];
            kr_r[2]  <= key[47:32];
            kr_r[3]  <= key[63:48];
            hold_x_r <= pt_x;
            hold_y_r <= pt_y;
            cnt_r    <= 5'd0;
          end
        end
        RUN: begin
          kr_r[0] <= kr_r[1];
          kr_r[1] <= kr_r[2];
          kr_r[2] <= kr_r[3];
          kr_r[3] <= knew_s;
          cnt_r   <= cnt_r + 5'd1;
        end
        DONE: begin
          ct_x <= x_out_s;
          ct_y <= y_out_s;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  simon_round round (
    .clk    (clk),
    .reset  (reset),
    .en     (round_en_s),
    .x_in   (x_in_s),
    .y_in   (y_in_s),
    .key_in (kr_r[0]),
    .x_out  (x_out_s),
    .y_out  (y_out_s)
  );

endmodule

// File: tb/tb_simon_encrypt_ctrl.sv
// Bench for simon_encrypt_ctrl: vector table plus random blocks checked against a
// Simon32/64 reference model through a ciphertext scoreboard.

module tb_simon_encrypt_ctrl;

  typedef struct {
    logic [63:0] key;
    logic [15:0] px;
    logic [15:0] py;
    logic [15:0] ex;
    logic [15:0] ey;
  } vec_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [15:0] KAT_PX  = 16'h6565;
  localparam logic [15:0] KAT_PY  = 16'h6877;
  localparam logic [15:0] KAT_CX  = 16'hC69B;
  localparam logic [15:0] KAT_CY  = 16'hE9BB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = 64'd0;
  logic [15:0] pt_x = 16'd0;
  logic [15:0] pt_y = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] ct_x;
  logic [15:0] ct_y;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic rst_q = 1'b1;
  logic [15:0] last_x = 16'd0;
  logic [15:0] last_y = 16'd0;
  vec_t vecs[6];

  simon_encrypt_ctrl #(.ROUNDS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .pt_x  (pt_x),
    .pt_y  (pt_y),
    .busy  (busy),
    .done  (done),
    .ct_x  (ct_x),
    .ct_y  (ct_y)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [31:0] simon_ref(input logic [63:0] k, input logic [15:0] x0, input logic [15:0] y0);
    logic [15:0] ks [32];
    logic [15:0] x, y, tmp;
    string z = "11111010001001010110000111001101";
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp = rotr(ks[i-1], 3) ^ ks[i-3];
      tmp = tmp ^ rotr(tmp, 1);
      ks[i] = ~ks[i-4] ^ tmp ^ ((z[i-4] == 8'h31) ? 16'd1 : 16'd0) ^ 16'd3;
    end
    x = x0;
    y = y0;
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ ks[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  // Scoreboard consumer and ciphertext-hold checker
  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (rst_q) begin
      last_x = ct_x;
      last_y = ct_y;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {ct_x, ct_y}, 32'hxxxx_xxxx);
      end else begin
        mon_e = sb.pop_front();
        chk("ciphertext", {ct_x, ct_y}, {mon_e.x, mon_e.y});
      end
      last_x = ct_x;
      last_y = ct_y;
    end else if ({ct_x, ct_y} !== {last_x, last_y}) begin
      chk("ct_hold", {ct_x, ct_y}, {last_x, last_y});
      last_x = ct_x;
      last_y = ct_y;
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'(done), 32'd1);
      sb.delete();
    end
  endtask

  task automatic run_one(input string name, input logic [63:0] k, input logic [15:0] px,
                         input logic [15:0] py, input logic [15:0] ex, input logic [15:0] ey);
    int   n;
    int   bcnt;
    exp_t e;
    key   = k;
    pt_x  = px;
    pt_y  = py;
    start = 1'b1;
    e.x = ex;
    e.y = ey;
    sb.push_back(e);
    tick();
    start = 1'b0;
    key   = {$urandom(), $urandom()};
    pt_x  = 16'($urandom());
    pt_y  = 16'($urandom());
    bcnt  = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    chk({name, "_latency"}, 32'(n), 32'd33);
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'd33);
    if (!done) sb.delete();
  endtask

  initial begin
    int n;
    int bcnt;
    int extra;
    logic [31:0] r;
    exp_t e;

    // Reset with start held high: nothing may start
    reset = 1'b1;
    start = 1'b1;
    key   = KAT_KEY;
    pt_x  = KAT_PX;
    pt_y  = KAT_PY;
    repeat (2) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ct", {ct_x, ct_y}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    r = simon_ref(KAT_KEY, KAT_PX, KAT_PY);
    chk("model_kat", r, {KAT_CX, KAT_CY});

    vecs[0] = '{KAT_KEY, KAT_PX, KAT_PY, KAT_CX, KAT_CY};
    vecs[1] = '{64'h0, 16'h0000, 16'h0000, 16'h0, 16'h0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0};
    vecs[3] = '{64'hAAAA_5555_AAAA_5555, 16'h5555, 16'hAAAA, 16'h0, 16'h0};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 16'h8000, 16'h0001, 16'h0, 16'h0};
    vecs[5] = '{64'h0000_0000_0000_0001, 16'h0000, 16'h0000, 16'h0, 16'h0};
    for (int i = 1; i < 6; i++) begin
      r = simon_ref(vecs[i].key, vecs[i].px, vecs[i].py);
      vecs[i].ex = r[31:16];
      vecs[i].ey = r[15:0];
    end
    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].key, vecs[i].px, vecs[i].py, vecs[i].ex, vecs[i].ey);
      tick();
    end

    // Start while busy must be ignored
    key = KAT_KEY; pt_x = KAT_PX; pt_y = KAT_PY; start = 1'b1;
    e.x = KAT_CX; e.y = KAT_CY;
    sb.push_back(e);
    tick();
    n = 0;
    while (!done && n < 100) begin
      if (n == 5 || n == 20) begin
        start = 1'b1;
        key   = {$urandom(), $urandom()};
        pt_x  = 16'($urandom());
        pt_y  = 16'($urandom());
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("busy_start_latency", 32'(n), 32'd33);
    extra = 0;
    repeat (40) begin
      tick();
      if (done) extra++;
    end
    chk("busy_start_extra_done", 32'(extra), 32'd0);

    // Back-to-back with start held high; inputs disturbed right after each accept
    key = KAT_KEY; pt_x = KAT_PX; pt_y = KAT_PY; start = 1'b1;
    sb.push_back(e);
    tick();
    for (int it = 0; it < 3; it++) begin
      key  = ~KAT_KEY;
      pt_x = ~KAT_PX;
      pt_y = ~KAT_PY;
      tick();
      key = KAT_KEY; pt_x = KAT_PX; pt_y = KAT_PY;
      wait_done("b2b", n);
      chk("b2b_latency", 32'(n + 1), 32'd33);
      chk("b2b_done_busy", 32'(busy), 32'd0);
      if (it < 2) sb.push_back(e);
      else        start = 1'b0;
      tick();
    end
    repeat (5) tick();

    // Reset mid-operation aborts with no done
    key = KAT_KEY; pt_x = KAT_PX; pt_y = KAT_PY; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ct", {ct_x, ct_y}, 32'd0);
    extra = 0;
    repeat (40) begin
      tick();
      if (done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    run_one("after_abort", KAT_KEY, KAT_PX, KAT_PY, KAT_CX, KAT_CY);
    tick();

    // Random blocks against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [63:0] k;
      logic [15:0] px, py;
      k  = {$urandom(), $urandom()};
      px = 16'($urandom());
      py = 16'($urandom());
      r  = simon_ref(k, px, py);
      run_one("rand", k, px, py, r[31:16], r[15:0]);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
